dct_blk_ctrl: RTL and testbench
===============================

DCT_BLK_CTRL -- requirements
Module: dct_blk_ctrl

Interface
REQ-001 Parameter: DCT_LAT, 6, cycles from dct_de high to that row's result valid at the 8-port DCT final stage.
REQ-002 Parameter: OUT_DEPTH, 8, row slots in downstream result buffer (initial credit count, range 1..15).
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_b  in  1  reset, asynchronous, active-low.
REQ-005 enable  in  1  level; 1 permits new blocks to start.
REQ-006 abort  in  1  sync pulse; discard block in progress and all in-flight rows.
REQ-007 s_valid  in  1  input row (8 pixels) valid.
REQ-008 s_ready  out  1  controller accepts row this cycle.
REQ-009 s_data  in  64  8 unsigned pixels; pixel k (k=1..8) in bits [8k-1:8k-8].
REQ-010 dct_de  out  1  registered data-enable to DCT datapath.
REQ-011 dct_data  out  64  registered row to DCT; same packing as s_data.
REQ-012 credit_ret  in  1  downstream freed one row slot.
REQ-013 res_valid  out  1  DCT result row valid this cycle.
REQ-014 res_row  out  3  row index (0..7) of current result.
REQ-015 res_last  out  1  res_valid and res_row==7.
REQ-016 res_blk  out  8  block index of current result.
REQ-017 busy  out  1  state!=IDLE or in-flight count!=0.
REQ-018 credit_err  out  1  sticky: credit_ret received with credits==OUT_DEPTH.

Function
REQ-019 FSM states IDLE, RUN, DRAIN; one-hot or binary at implementer's choice.
REQ-020 Accept = s_valid & s_ready; s_ready=1 only in RUN with credits>0 and abort==0.
REQ-021 IDLE->RUN when enable==1 and abort==0; s_ready=0 in IDLE.
REQ-022 Row counter in_row 0..7 increments per accept, wraps 7->0.
REQ-023 Blocks atomic: RUN->DRAIN only on accept with in_row==7 while enable==0; enable drop mid-block does not stop acceptance.
REQ-024 DRAIN: s_ready=0; DRAIN->IDLE when in-flight count==0 and no res_valid this cycle.
REQ-025 Accept at edge t: dct_de=1 and dct_data=s_data during cycle t+1; otherwise dct_de=0, dct_data holds last value.
REQ-026 res_valid = dct_de delayed DCT_LAT cycles via shift register; total accept-to-res_valid latency DCT_LAT+1 cycles.
REQ-027 Results in order: res_row counter increments per res_valid, wraps 7->0; res_blk increments after res_last, wraps 255->0.
REQ-028 Credits: 4-bit, decrement on accept, increment on credit_ret; both same cycle -> unchanged; never exceed OUT_DEPTH (excess ignored, credit_err set).
REQ-029 In-flight count (0..DCT_LAT+1): +1 on accept, -1 on res_valid, both -> unchanged.
REQ-030 Back-to-back accepts permitted every cycle while credits>0.
REQ-031 abort (any state): next cycle state=IDLE, in_row=0, res_row=0, res_blk=0, credits=OUT_DEPTH, in-flight=0, valid shift register cleared, dct_de=0; s_ready=0 during abort cycle.
REQ-032 abort and accept same cycle: abort wins, row not accepted.
REQ-033 IDLE->RUN not taken in abort cycle even if enable==1.

Reset
REQ-034 rst_b low: state IDLE, s_ready=0, dct_de=0, dct_data=0, res_valid=0, res_row=0, res_last=0, res_blk=0, busy=0, credit_err=0, credits=OUT_DEPTH, in-flight=0, shift register 0.
REQ-035 credit_err clears only on rst_b.
REQ-036 Reset assertion mid-block discards all state immediately; no res_valid after release until new accepts.

Verification
REQ-037 enable=1, 8 consecutive rows, credit_ret every cycle -> dct_de cycles 1..8 after first accept, res_valid 7 cycles after each accept, res_row 0..7, res_last on 8th, res_blk=0 then 1.
REQ-038 OUT_DEPTH=8, no credit_ret, s_valid held -> exactly 8 accepts then s_ready=0; one credit_ret -> exactly one more accept.
REQ-039 enable dropped after row 3 accepted -> rows 4..7 still accepted, DRAIN, busy falls 1 cycle after res_last, state IDLE.
REQ-040 abort 2 cycles after row 5 accept -> no further res_valid, res_blk=0, credits=8, s_ready=1 one cycle after re-entering RUN.
REQ-041 credit_ret with credits=8 -> credits stay 8, credit_err=1 until rst_b.
REQ-042 rst_b pulsed low mid-block -> all outputs reset values asynchronously, none asserted until new accept.

Source files
------------

// File: rtl/dct_blk_ctrl.sv
// Block controller for an 8-point row DCT: admits 8-row pixel blocks under
// downstream credit control, tracks rows in flight and tags results with row/block indices.
module dct_blk_ctrl #(
  parameter int DCT_LAT   = 6,
  parameter int OUT_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        enable,
  input  logic        abort,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [63:0] s_data,
  output logic        dct_de,
  output logic [63:0] dct_data,
  input  logic        credit_ret,
  output logic        res_valid,
  output logic [2:0]  res_row,
  output logic        res_last,
  output logic [7:0]  res_blk,
  output logic        busy,
  output logic        credit_err
);

  localparam int              IF_W     = $clog2(DCT_LAT + 2);
  localparam logic [3:0]      CRED_MAX = 4'(OUT_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state, state_nxt;
  logic [2:0]         in_row;
  logic [3:0]         credits;
  logic [IF_W-1:0]    inflight;
  logic [DCT_LAT-1:0] vld_p;
  logic               accept;
  logic               cred_over;
  logic               cred_inc;

  assign s_ready   = (state == RUN) && (credits != '0) && !abort;
  assign accept    = s_valid && s_ready;
  assign res_valid = vld_p[DCT_LAT-1];
  assign res_last  = res_valid && (res_row == 3'd7);
  assign busy      = (state != IDLE) || (inflight != '0);

  // A return that would push credits past the buffer depth is dropped and flagged;
  // paired with an accept it is a legitimate swap and nets to no change.
  assign cred_over = credit_ret && !accept && (credits == CRED_MAX);
  assign cred_inc  = credit_ret && !cred_over;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (accept && (in_row == 3'd7) && !enable) state_nxt = DRAIN;
      DRAIN:   if ((inflight == '0) && !res_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state      <= IDLE;
      in_row     <= '0;
      credits    <= CRED_MAX;
      inflight   <= '0;
      credit_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (cred_over) credit_err <= 1'b1;
      if (abort) begin
        in_row   <= '0;
        credits  <= CRED_MAX;
        inflight <= '0;
      end else begin
        if (accept) in_row <= in_row + 3'd1;
        if (cred_inc && !accept)      credits <= credits + 4'd1;
        else if (accept && !cred_inc) credits <= credits - 4'd1;
        if (accept && !res_valid)      inflight <= inflight + IF_W'(1);
        else if (res_valid && !accept) inflight <= inflight - IF_W'(1);
      end
    end
  end

  // Stage p0: registered row launch into the DCT datapath
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      dct_de   <= 1'b0;
      dct_data <= '0;
    end else begin
      dct_de <= accept && !abort;
      if (accept) dct_data <= s_data;
    end
  end

  // Stages p1..pN: valid shadow of the DCT pipeline and result tagging
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      vld_p   <= '0;
      res_row <= '0;
      res_blk <= '0;
    end else if (abort) begin
      vld_p   <= '0;
      res_row <= '0;
      res_blk <= '0;
    end else begin
      vld_p <= (vld_p << 1) | DCT_LAT'(dct_de);
      if (res_valid) res_row <= res_row + 3'd1;
      if (res_last)  res_blk <= res_blk + 8'd1;
    end
  end

endmodule

// File: tb/tb_dct_blk_ctrl.sv
// Directed bench for dct_blk_ctrl: a negedge monitor scoreboards every accepted row
// against its result (latency, row, block, last) while the main sequence steps scenarios.
module tb_dct_blk_ctrl;

  logic        clk = 1'b0;
  logic        rst_b, enable, abort, s_valid, credit_ret;
  logic [63:0] s_data;
  logic        s_ready, dct_de, res_valid, res_last, busy, credit_err;
  logic [63:0] dct_data;
  logic [2:0]  res_row;
  logic [7:0]  res_blk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  typedef struct {
    int row;
    int blk;
    int due;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          acc_cnt  = 0;
  logic        exp_de   = 1'b0;
  logic [63:0] exp_data = '0;
  logic        mon_acc;

  dct_blk_ctrl #(.DCT_LAT(6), .OUT_DEPTH(8)) dut (
    .clk(clk), .rst_b(rst_b), .enable(enable), .abort(abort),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .dct_de(dct_de), .dct_data(dct_data), .credit_ret(credit_ret),
    .res_valid(res_valid), .res_row(res_row), .res_last(res_last),
    .res_blk(res_blk), .busy(busy), .credit_err(credit_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string p);
    chk({p, "s_ready"},    64'(s_ready),    64'(0));
    chk({p, "dct_de"},     64'(dct_de),     64'(0));
    chk({p, "dct_data"},   dct_data,        64'(0));
    chk({p, "res_valid"},  64'(res_valid),  64'(0));
    chk({p, "res_row"},    64'(res_row),    64'(0));
    chk({p, "res_last"},   64'(res_last),   64'(0));
    chk({p, "res_blk"},    64'(res_blk),    64'(0));
    chk({p, "busy"},       64'(busy),       64'(0));
    chk({p, "credit_err"}, 64'(credit_err), 64'(0));
  endtask

  // Offer n rows back to back, returning one credit alongside each accept.
  task automatic feed(input int n, input logic en);
    for (int i = 0; i < n; i++) begin
      enable = en; s_valid = 1'b1; credit_ret = 1'b1;
      s_data = {$urandom, $urandom};
      #1 chk("s_ready_feed", 64'(s_ready), 64'(1));
      tick();
    end
    s_valid = 1'b0; credit_ret = 1'b0;
  endtask

  task automatic count_acc(input int cycles, output int n);
    n = 0; credit_ret = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      s_valid = 1'b1; s_data = {$urandom, $urandom};
      #1 if (s_ready) n++;
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic give_credits(input int n);
    for (int i = 0; i < n; i++) begin
      credit_ret = 1'b1;
      tick();
    end
    credit_ret = 1'b0;
  endtask

  task automatic drain(input int lim);
    int k = 0;
    while (q.size() != 0 && k < lim) begin
      tick();
      k++;
    end
    chk("drain_timeout", 64'(q.size()), 64'(0));
  endtask

  // Scoreboard monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_b) begin
        q.delete(); acc_cnt = 0; exp_de = 1'b0; exp_data = '0;
      end else begin
        chk("dct_de", 64'(dct_de), 64'(exp_de));
        chk("dct_data", dct_data, exp_data);
        if (q.size() == 0) begin
          chk("res_valid_idle", 64'(res_valid), 64'(0));
        end else if (res_valid || q[0].due <= cyc) begin
          mon_e = q.pop_front();
          chk("res_valid", 64'(res_valid), 64'(1));
          chk("res_latency", 64'(cyc), 64'(mon_e.due));
          chk("res_row", 64'(res_row), 64'(mon_e.row));
          chk("res_blk", 64'(res_blk), 64'(mon_e.blk));
          chk("res_last", 64'(res_last), 64'(mon_e.row == 7));
        end
        mon_acc = s_valid && s_ready && !abort;
        exp_de = mon_acc;
        if (mon_acc) begin
          exp_data = s_data;
          q.push_back('{acc_cnt % 8, (acc_cnt / 8) % 256, cyc + 7});
          acc_cnt++;
        end
        if (abort) begin
          q.delete(); acc_cnt = 0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_b = 1'b0; enable = 1'b0; abort = 1'b0; s_valid = 1'b0;
    credit_ret = 1'b0; s_data = '0;
    tick(); tick();
    chk_reset("rst_");
    rst_b = 1'b1;
    tick();

    // Two full blocks streamed with credits returned every cycle
    enable = 1'b1;
    tick();
    chk("run_s_ready", 64'(s_ready), 64'(1));
    chk("run_busy", 64'(busy), 64'(1));
    feed(16, 1'b1);
    drain(30);

    // Credit exhaustion and single-credit release
    count_acc(14, n);
    chk("credit_accepts", 64'(n), 64'(8));
    s_valid = 1'b1; credit_ret = 1'b1;
    #1 chk("no_credit_s_ready", 64'(s_ready), 64'(0));
    tick();
    credit_ret = 1'b0;
    count_acc(6, n);
    chk("one_credit_accepts", 64'(n), 64'(1));
    give_credits(8);
    feed(7, 1'b1);
    drain(30);

    // Enable dropped mid-block: block completes, then drain to idle
    feed(4, 1'b1);
    feed(4, 1'b0);
    s_valid = 1'b1;
    #1 chk("drain_s_ready", 64'(s_ready), 64'(0));
    s_valid = 1'b0;
    chk("drain_busy", 64'(busy), 64'(1));
    for (int i = 0; i < 20; i++) begin
      if (res_last) break;
      tick();
    end
    chk("drain_res_last", 64'(res_last), 64'(1));
    chk("busy_at_last", 64'(busy), 64'(1));
    tick(); tick();
    chk("busy_after_drain", 64'(busy), 64'(0));
    s_valid = 1'b1;
    #1 chk("idle_s_ready", 64'(s_ready), 64'(0));
    s_valid = 1'b0;
    drain(5);

    // Abort two cycles after row 5 of a block
    enable = 1'b1;
    tick();
    feed(6, 1'b1);
    tick();
    chk("pre_abort_busy", 64'(busy), 64'(1));
    abort = 1'b1; s_valid = 1'b1;
    #1 chk("abort_s_ready", 64'(s_ready), 64'(0));
    tick();
    abort = 1'b0; s_valid = 1'b0;
    #1 chk("post_abort_s_ready", 64'(s_ready), 64'(0));
    chk("post_abort_busy", 64'(busy), 64'(0));
    chk("post_abort_res_row", 64'(res_row), 64'(0));
    chk("post_abort_res_blk", 64'(res_blk), 64'(0));
    tick();
    chk("rerun_s_ready", 64'(s_ready), 64'(1));
    count_acc(10, n);
    chk("abort_credits", 64'(n), 64'(8));
    give_credits(8);
    drain(30);

    // Excess credit return
    chk("credit_err_clear", 64'(credit_err), 64'(0));
    credit_ret = 1'b1;
    tick();
    credit_ret = 1'b0;
    chk("credit_err_set", 64'(credit_err), 64'(1));
    count_acc(12, n);
    chk("excess_credits", 64'(n), 64'(8));
    give_credits(8);
    drain(30);
    chk("credit_err_sticky", 64'(credit_err), 64'(1));

    // Asynchronous reset mid-block
    feed(3, 1'b1);
    enable = 1'b0;
    #1 rst_b = 1'b0;
    #1 chk_reset("async_rst_");
    tick(); tick();
    rst_b = 1'b1;
    for (int i = 0; i < 12; i++) begin
      chk("post_rst_res_valid", 64'(res_valid), 64'(0));
      chk("post_rst_dct_de", 64'(dct_de), 64'(0));
      tick();
    end
    chk("post_rst_busy", 64'(busy), 64'(0));
    enable = 1'b1;
    tick();
    feed(8, 1'b1);
    drain(30);
    chk("final_credit_err", 64'(credit_err), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
